// File: rtl/mimo_pkg.sv
// Shared widths, symbol relabel table, FIFO entry and FSM encoding
// for the MIMO detector result packer.
package mimo_pkg;

    localparam int WORD_W = 32;
    localparam int RES_W  = 12;
    localparam int SYM_W  = 3;
    localparam int NSYM   = RES_W / SYM_W;
    localparam int EXT_W  = WORD_W + RES_W;

    // Entry k holds the relabelled value of symbol k.
    localparam logic [8*SYM_W-1:0] GRAY_TBL = {
        3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] word;
    } fifo_ent_t;

    function automatic logic [RES_W-1:0] gray_relabel(
        input logic [RES_W-1:0] r
    );
        logic [RES_W-1:0] o;
        logic [SYM_W-1:0] s;
        o = '0;
        for (int k = 0; k < NSYM; k++) begin
            s = r[k*SYM_W +: SYM_W];
            o[k*SYM_W +: SYM_W] = GRAY_TBL[int'(s)*SYM_W +: SYM_W];
        end
        return o;
    endfunction

endpackage

// File: rtl/mimo_word_fifo.sv
// First-word-fall-through word FIFO; push and pop may coincide at any
// occupancy, almost-full is registered from post-edge occupancy.
module mimo_word_fifo
    import mimo_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AF_FREE = 1,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  fifo_ent_t       din_i,
    input  logic            ready_i,
    output logic            valid_o,
    output fifo_ent_t       dout_o,
    output logic [CW-1:0]   count_o,
    output logic            afull_o,
    output logic            space_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fifo_ent_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            afull_q;
    logic            pop;
    logic            wr;

    assign valid_o = (cnt_q != '0);
    assign pop     = valid_o && ready_i;
    assign space_o = (cnt_q != FULL) || pop;
    assign wr      = push_i && space_o;
    assign dout_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;
    assign afull_o = afull_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({wr, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            afull_q <= 1'b0;
        end else begin
            if (wr)  wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q   <= cnt_d;
            afull_q <= (FULL - cnt_d) <= CW'(AF_FREE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/mimo_result_packer.sv
// Packs 12-bit detector results LSB-first into 32-bit words behind a FWFT FIFO.
// Define MIMO_PACK_GRAY_EN to relabel each 3-bit symbol before packing.
module mimo_result_packer
    import mimo_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AF_FREE = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         i_valid,
    input  logic [RES_W-1:0]             i_data,
    input  logic                         i_flush,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [WORD_W-1:0]            o_data,
    output logic                         o_last,
    output logic                         o_almost_full,
    output logic                         o_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [4:0]        fill_q, fill_d;
    logic [2:0]        phase_q, phase_d;
    logic              ovf_q, ovf_d;
    logic [RES_W-1:0]  res;
    logic [EXT_W-1:0]  ext;
    logic              completes;
    logic              space;
    logic              push;
    fifo_ent_t         push_ent;
    fifo_ent_t         head;

`ifdef MIMO_PACK_GRAY_EN
    assign res = gray_relabel(i_data);
`else
    assign res = i_data;
`endif

    // Bits above fill in acc_q are always zero, so OR-ing is enough.
    assign ext       = (EXT_W'(res) << fill_q) | EXT_W'(acc_q);
    assign completes = fill_q >= 5'(WORD_W - RES_W);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        fill_d   = fill_q;
        phase_d  = phase_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        push_ent = '0;
        unique case (state_q)
            S_FLUSH: begin
                if (i_valid) ovf_d = 1'b1;
                if (fill_q == '0) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                end else if (space) begin
                    push     = 1'b1;
                    push_ent = '{last: 1'b1, word: acc_q};
                    acc_d    = '0;
                    fill_d   = '0;
                    phase_d  = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                if (i_valid) begin
                    if (completes && !space) begin
                        ovf_d = 1'b1;
                    end else begin
                        phase_d = phase_q + 3'd1;
                        fill_d  = fill_q + 5'(RES_W);
                        if (completes) begin
                            push     = 1'b1;
                            push_ent = '{last: 1'b0, word: ext[WORD_W-1:0]};
                            acc_d    = WORD_W'(ext[EXT_W-1:WORD_W]);
                        end else begin
                            acc_d = ext[WORD_W-1:0];
                        end
                        state_d = (fill_d != '0) ? S_ACCUM : S_IDLE;
                    end
                end
                // A same-cycle result is appended first; the flush runs next.
                if (i_flush) state_d = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    mimo_word_fifo #(
        .DEPTH   (DEPTH),
        .AF_FREE (AF_FREE)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .din_i   (push_ent),
        .ready_i (o_ready),
        .valid_o (o_valid),
        .dout_o  (head),
        .count_o (o_count),
        .afull_o (o_almost_full),
        .space_o (space)
    );

    assign o_data     = head.word;
    assign o_last     = head.last;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_mimo_result_packer.sv
// Self-checking bench for mimo_result_packer: directed vectors plus
// randomized traffic against a bit-queue reference model.
module tb_mimo_result_packer;

    localparam int DEPTH   = 4;
    localparam int AF_FREE = 1;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [11:0]   i_data = '0;
    logic          i_flush = 1'b0;
    logic          o_ready = 1'b0;
    logic          o_valid;
    logic [31:0]   o_data;
    logic          o_last;
    logic          o_almost_full;
    logic          o_overflow;
    logic [CW-1:0] o_count;

    int checks = 0;
    int errors = 0;

    mimo_result_packer #(
        .DEPTH   (DEPTH),
        .AF_FREE (AF_FREE)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow),
        .o_count       (o_count)
    );

    always #5 Clk = ~Clk;

    // Reference model: pending bits as a queue, output words as a queue.
    bit          mbits[$];
    logic [32:0] mq[$];
    bit          mpend;
    bit          movf;

    function automatic logic [11:0] mmap(input logic [11:0] d);
        logic [11:0] o;
        logic [2:0]  s;
        o = d;
`ifdef MIMO_PACK_GRAY_EN
        for (int k = 0; k < 4; k++) begin
            s = d[3*k +: 3];
            o[3*k +: 3] = s ^ (s >> 1);
        end
`endif
        return o;
    endfunction

    task automatic model_step(input bit v, input logic [11:0] d,
                              input bit f, input bit r, input bit rst);
        bit          pop;
        bit          space;
        bit          dopush;
        logic [32:0] pw;
        logic [11:0] rv;
        pop    = (mq.size() > 0) && r;
        space  = (mq.size() < DEPTH) || pop;
        dopush = 0;
        pw     = '0;
        if (rst) begin
            mbits.delete();
            mq.delete();
            mpend = 0;
            movf  = 0;
        end else begin
            if (mpend) begin
                if (v) movf = 1;
                if (mbits.size() == 0) begin
                    mpend = 0;
                end else if (space) begin
                    for (int i = 0; i < mbits.size(); i++) pw[i] = mbits[i];
                    pw[32] = 1'b1;
                    mbits.delete();
                    dopush = 1;
                    mpend  = 0;
                end
            end else begin
                if (v) begin
                    if (mbits.size() + 12 >= 32 && !space) begin
                        movf = 1;
                    end else begin
                        rv = mmap(d);
                        for (int i = 0; i < 12; i++) mbits.push_back(rv[i]);
                        if (mbits.size() >= 32) begin
                            for (int i = 0; i < 32; i++) pw[i] = mbits.pop_front();
                            dopush = 1;
                        end
                    end
                end
                if (f) mpend = 1;
            end
            if (pop) void'(mq.pop_front());
            if (dopush) mq.push_back(pw);
        end
    endtask

    function automatic logic [63:0] model_out();
        bit          ev;
        logic [32:0] h;
        int          free;
        ev   = (mq.size() > 0);
        h    = ev ? mq[0] : '0;
        free = DEPTH - mq.size();
        return {24'b0, ev, h[32], (free <= AF_FREE), movf,
                4'(mq.size()), h[31:0]};
    endfunction

    function automatic logic [63:0] dut_out();
        return {24'b0, o_valid, o_last, o_almost_full, o_overflow,
                4'(o_count), o_data};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [11:0] d, input bit f,
                       input bit r, input bit rst);
        i_valid = v;
        i_data  = d;
        i_flush = f;
        o_ready = r;
        Reset   = rst;
        model_step(v, d, f, r, rst);
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        bit          v;
        logic [11:0] d;
        bit          f;
        bit          r;
        bit          ev;
        bit          el;
        logic [31:0] ed;
        int          ec;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input bit v, input logic [11:0] d, input bit f,
                        input bit ev, input bit el, input logic [31:0] ed,
                        input int ec);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.r = 1'b1;
        t.ev = ev; t.el = el; t.ed = ed; t.ec = ec;
        tbl.push_back(t);
    endtask

    initial begin
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        chk("reset_state", dut_out(), 64'd0);

`ifndef MIMO_PACK_GRAY_EN
        addv(1, 12'h123, 0, 0, 0, 32'h0, 0);
        addv(1, 12'h456, 0, 0, 0, 32'h0, 0);
        addv(1, 12'h789, 0, 1, 0, 32'h89456123, 1);
        addv(0, 12'h000, 1, 0, 0, 32'h0, 0);
        addv(0, 12'h000, 0, 1, 1, 32'h00000007, 1);
        addv(0, 12'h000, 0, 0, 0, 32'h0, 0);
        addv(1, 12'hFFF, 0, 0, 0, 32'h0, 0);
        addv(1, 12'hFFF, 0, 0, 0, 32'h0, 0);
        addv(1, 12'hFFF, 0, 1, 0, 32'hFFFFFFFF, 1);
        addv(1, 12'hFFF, 0, 0, 0, 32'h0, 0);
        addv(1, 12'hFFF, 0, 0, 0, 32'h0, 0);
        addv(1, 12'hFFF, 0, 1, 0, 32'hFFFFFFFF, 1);
        addv(1, 12'hFFF, 0, 0, 0, 32'h0, 0);
        addv(1, 12'hFFF, 0, 1, 0, 32'hFFFFFFFF, 1);
        addv(0, 12'h000, 1, 0, 0, 32'h0, 0);
        addv(0, 12'h000, 0, 0, 0, 32'h0, 0);
        addv(0, 12'h000, 0, 0, 0, 32'h0, 0);
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r, 0);
            chk($sformatf("vec%0d", i),
                {o_valid, o_last, 4'(o_count), o_data},
                {tbl[i].ev, tbl[i].el, 4'(tbl[i].ec), tbl[i].ed});
        end

        // Fill the FIFO with o_ready low, then overflow on a completing result.
        cyc(0, '0, 0, 0, 1);
        for (int i = 1; i <= 14; i++) begin
            cyc(1, 12'hFFF, 0, 0, 0);
            if (i == 7)  chk("af_at_2", {o_almost_full, 4'(o_count)}, {1'b0, 4'd2});
            if (i == 8)  chk("af_at_3", {o_almost_full, 4'(o_count)}, {1'b1, 4'd3});
            if (i == 11) chk("full_4", {o_almost_full, 4'(o_count)}, {1'b1, 4'd4});
            if (i == 13) chk("no_ovf_partial", {o_overflow, 4'(o_count)}, {1'b0, 4'd4});
            if (i == 14) chk("ovf_drop", {o_overflow, 4'(o_count)}, {1'b1, 4'd4});
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), {o_valid, o_data}, {1'b1, 32'hFFFFFFFF});
            cyc(0, '0, 0, 1, 0);
        end
        chk("drained", {o_valid, o_almost_full, 4'(o_count)}, 6'd0);
        cyc(0, '0, 1, 1, 0);
        cyc(0, '0, 0, 0, 0);
        chk("acc_kept", {o_valid, o_last, o_overflow, o_data},
            {3'b111, 32'h0FFFFFFF});
        cyc(0, '0, 0, 1, 0);

        // Reset mid-frame with two words queued and a partial word.
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 12'h5A5, 0, 0, 0);
        chk("two_queued", 4'(o_count), 4'd2);
        cyc(0, '0, 0, 0, 1);
        chk("mid_reset", {o_valid, o_overflow, 4'(o_count), o_data}, 38'd0);
        cyc(1, 12'h123, 0, 0, 0);
        cyc(1, 12'h456, 0, 0, 0);
        cyc(1, 12'h789, 0, 0, 0);
        chk("post_reset_w0", {o_valid, o_last, 4'(o_count), o_data},
            {2'b10, 4'd1, 32'h89456123});
        cyc(0, '0, 1, 1, 0);
        cyc(0, '0, 0, 0, 0);
        chk("post_reset_flush", {o_valid, o_last, o_data}, {2'b11, 32'h7});
`else
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 12'hFFF, 0, 0, 0);
        chk("gray_w0", {o_valid, o_last, o_data}, {2'b10, 32'h24924924});
`endif

        // Randomized traffic with varying downstream readiness.
        cyc(0, '0, 0, 0, 1);
        for (int seg = 0; seg < 15; seg++) begin
            int rp;
            rp = (seg % 3 == 0) ? 15 : (seg % 3 == 1) ? 60 : 95;
            for (int c = 0; c < 200; c++) begin
                cyc($urandom_range(0, 99) < 45, 12'($urandom),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < rp,
                    $urandom_range(0, 999) == 0);
                chk($sformatf("rand_s%0d_c%0d", seg, c), dut_out(), model_out());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
